// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, state type and helpers for regfile_mp
// Purpose: default data width, init/ready state enum, address-width helper.
// Ports: none (package).
package regfile_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   function automatic int addr_width(input int nregs);
      return $clog2(nregs);
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file port bundle between decode/writeback and the array
// Purpose: groups clear, write ports, read ports and status of regfile_mp.
// Ports (master drives / slave receives):
//   clear_req, wr_en[NWR], wr_addr[NWR*AW], wr_data[NWR*XLEN], rd_addr[NRD*AW]
//   ready, rd_data[NRD*XLEN], wr_conflict (driven by the slave)
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1
) ();
   localparam int AW = addr_width(NREGS);

   logic                clear_req;
   logic                ready;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                wr_conflict;

   modport master (
      output clear_req, wr_en, wr_addr, wr_data, rd_addr,
      input  ready, rd_data, wr_conflict
   );

   modport slave (
      input  clear_req, wr_en, wr_addr, wr_data, rd_addr,
      output ready, rd_data, wr_conflict
   );
endinterface

// File: rtl/regfile_init_fsm.sv
// rtl/regfile_init_fsm.sv - clear sweep sequencer for the register array
// Purpose: owns INIT/READY state and the sweep counter; zeroes reg[1..NREGS-1]
//          one entry per clock after reset or a clear request.
// Ports: clk, rst_n (async, active-low), clear_req in;
//        ready, sweep_we, sweep_addr[AW] out.
module regfile_init_fsm
   import regfile_pkg::*;
#(
   parameter int NREGS = 32,
   localparam int AW = addr_width(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_req,
   output logic          ready,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_addr
);
   localparam logic [AW-1:0] ONE  = AW'(1);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t        state, state_nx;
   logic [AW-1:0] cnt, cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= ONE;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // reg[0] is hardwired, so the sweep starts at 1 and ends on NREGS-1.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      sweep_we   = 1'b0;
      sweep_addr = cnt;
      case (state)
         INIT: begin
            sweep_we = 1'b1;
            if (clear_req) begin
               cnt_nx = ONE;
            end else if (cnt == LAST) begin
               state_nx = READY;
               cnt_nx   = ONE;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         READY: begin
            if (clear_req) begin
               state_nx = INIT;
               cnt_nx   = ONE;
            end
         end
      endcase
   end

   assign ready = (state == READY);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port integer register file
// Purpose: NRD combinational read ports, NWR write ports (higher port wins on
//          same address), hardwired-zero reg[0], registered write-conflict flag,
//          sequential clear sweep instead of an array reset.
// Optional: REGFILE_BYPASS_EN forwards same-cycle accepted writes to reads.
// Ports: clk, rst_n (async, active-low); bus (regfile_mp_if.slave).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1,
   localparam int AW = addr_width(NREGS)
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_mp_if.slave bus
);
   logic            ready;
   logic            sweep_we;
   logic [AW-1:0]   sweep_addr;
   logic            accept;
   logic            conflict_d;
   logic            conflict_q;
   logic [XLEN-1:0] mem [NREGS];

   regfile_init_fsm #(.NREGS(NREGS)) u_init_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_req  (bus.clear_req),
      .ready      (ready),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // The cycle that samples clear_req also drops writes.
   assign accept = ready && !bus.clear_req;

   // No reset on storage; the sweep establishes the zero state. Later ports
   // are written last, so port 1 overrides port 0 on the same address.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[sweep_addr] <= '0;
      end else if (accept) begin
         for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0))
               mem[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
         end
      end
   end

   generate
      if (NWR > 1) begin : g_conflict
         assign conflict_d = accept && bus.wr_en[0] && bus.wr_en[1] &&
                             (bus.wr_addr[0 +: AW] == bus.wr_addr[AW +: AW]) &&
                             (bus.wr_addr[0 +: AW] != '0);
      end else begin : g_no_conflict
         assign conflict_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         conflict_q <= 1'b0;
      else
         conflict_q <= conflict_d;
   end

   logic [AW-1:0]   ra;
   logic [XLEN-1:0] val;

   always_comb begin
      bus.rd_data = '0;
      ra          = '0;
      val         = '0;
      for (int r = 0; r < NRD; r++) begin
         ra  = bus.rd_addr[r*AW +: AW];
         val = '0;
         if (ready && (ra != '0)) begin
            val = mem[ra];
`ifdef REGFILE_BYPASS_EN
            // Loop order gives the highest matching write port priority.
            for (int p = 0; p < NWR; p++) begin
               if (accept && bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == ra))
                  val = bus.wr_data[p*XLEN +: XLEN];
            end
`endif
         end
         bus.rd_data[r*XLEN +: XLEN] = val;
      end
   end

   assign bus.ready       = ready;
   assign bus.wr_conflict = conflict_q;

endmodule
